// File: rtl/sb_queue_reset_seq.sv
// sb_queue_reset_seq: drain-and-reset sequencer for one switchboard queue.
// Optional drain timeout is built when SB_RESET_SEQ_TIMEOUT_EN is defined.
module sb_queue_reset_seq #(
  parameter int NUM_QUEUES   = 2,
  parameter int RESET_CYCLES = 4,
  parameter int TIMEOUT_W    = 16,
  localparam int QW  = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  req_valid,
  input  logic [QW-1:0]         req_queue,
  output logic                  req_ready,
  input  logic [NUM_QUEUES-1:0] host_enable,
  input  logic [NUM_QUEUES-1:0] host_reset,
  input  logic [NUM_QUEUES-1:0] status_idle,
  output logic [NUM_QUEUES-1:0] cfg_enable,
  output logic [NUM_QUEUES-1:0] cfg_reset,
  input  logic [TIMEOUT_W-1:0]  timeout_limit,
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic                  done_err,
  output logic                  done_timeout,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_RST   = 3'd2,
    S_REEN  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [RCW-1:0] RC_LAST = RCW'(RESET_CYCLES - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [QW-1:0]           q;
  logic [QW-1:0]           q_nxt;
  logic [NUM_QUEUES-1:0]   q_oh;
  logic [NUM_QUEUES-1:0]   nq_oh;
  logic [NUM_QUEUES-1:0]   dis_nxt;
  logic [NUM_QUEUES-1:0]   rst_nxt;
  logic [RCW-1:0]          rcnt;
  logic                    armed;
  logic                    accept;
  logic                    bad;
  logic                    q_idle;
  logic                    tmo_hit;
  logic                    tmo_exit;
  logic                    err_r;

  assign bad    = (int'(req_queue) >= NUM_QUEUES);
  assign q_nxt  = accept ? req_queue : q;
  assign q_oh   = NUM_QUEUES'(1) << q;
  assign nq_oh  = NUM_QUEUES'(1) << q_nxt;
  assign q_idle = |(status_idle & q_oh);

`ifdef SB_RESET_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] timer;
  logic [TIMEOUT_W-1:0] timer_inc;
  logic                 tmo_r;

  assign timer_inc = (&timer) ? timer : timer + 1'b1;
  assign tmo_hit   = (timeout_limit != '0) &&
                     (timer_inc == timeout_limit);

  // drain timer: counts completed DRAIN cycles, saturating
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      timer <= '0;
    end else if (accept) begin
      timer <= '0;
    end else if (state == S_DRAIN) begin
      timer <= timer_inc;
    end
  end

  // timeout flag: set on a timed-out drain exit
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tmo_r <= 1'b0;
    end else if (accept) begin
      tmo_r <= 1'b0;
    end else if (tmo_exit) begin
      tmo_r <= 1'b1;
    end else if (state == S_DONE && done_ready) begin
      tmo_r <= 1'b0;
    end
  end

  assign done_timeout = tmo_r;
`else
  logic unused_limit;

  assign unused_limit = ^timeout_limit;
  assign tmo_hit      = 1'b0;
  assign done_timeout = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    tmo_exit  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = bad ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (armed && q_idle) begin
          state_nxt = S_RST;
        end else if (tmo_hit) begin
          state_nxt = S_RST;
          tmo_exit  = 1'b1;
        end
      end
      S_RST: begin
        if (rcnt == RC_LAST) begin
          state_nxt = S_REEN;
        end
      end
      S_REEN: begin
        state_nxt = S_DONE;
      end
      S_DONE: begin
        if (done_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // output decode: masks follow the state being entered
  always_comb begin
    dis_nxt    = '0;
    rst_nxt    = '0;
    req_ready  = nreset && (state == S_IDLE);
    done_valid = (state == S_DONE);
    busy       = (state != S_IDLE);
    unique case (1'b1)
      (state_nxt == S_RST): begin
        dis_nxt = nq_oh;
        rst_nxt = nq_oh;
      end
      (state_nxt == S_DRAIN),
      (state_nxt == S_REEN): begin
        dis_nxt = nq_oh;
      end
      default: begin
      end
    endcase
  end

  // sequence context: queue index, drain arm, reset count
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      q     <= '0;
      armed <= 1'b0;
      rcnt  <= '0;
    end else begin
      q     <= q_nxt;
      armed <= (state == S_DRAIN);
      rcnt  <= (state == S_RST) ? rcnt + 1'b1 : '0;
    end
  end

  // error flag for out-of-range requests
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      err_r <= 1'b0;
    end else if (accept) begin
      err_r <= bad;
    end else if (state == S_DONE && done_ready) begin
      err_r <= 1'b0;
    end
  end

  assign done_err = err_r;

  // gated config to the queue engines
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cfg_enable <= '0;
      cfg_reset  <= '0;
    end else begin
      cfg_enable <= host_enable & ~dis_nxt;
      cfg_reset  <= host_reset | rst_nxt;
    end
  end

endmodule
